// File: rtl/axi_probe_target.sv
// AXI4-Lite style register target: DEPTH word-indexed 32-bit registers with byte strobes,
// independent read/write channel FSMs and completed-response counters.
module axi_probe_target #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 16
) (
  input  logic        clk,
  input  logic        m_aresetn,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} w_state_e;

  // A miss outranks an oversized access.
  function automatic logic [1:0] resp_of(input logic [31:0] addr, input logic [2:0] size);
    if ((addr - BASE_ADDR) >= 32'(DEPTH)) return RESP_DECERR;
    if (size > 3'b010)                    return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] addr);
    return IDX_W'(addr - BASE_ADDR);
  endfunction

  r_state_e    r_state_q, r_state_d;
  w_state_e    w_state_q, w_state_d;
  logic        ready_en_q, ready_en_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  logic ar_hs, aw_hs, w_hs, w_done;
  logic [IDX_W-1:0] widx;

  // State register. NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      r_state_q  <= R_IDLE;
      w_state_q  <= W_IDLE;
      ready_en_q <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      awaddr_q   <= '0;
      awsize_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
      // NOTE: the register array is cleared by reset, so it is built from flops, not a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      r_state_q  <= r_state_d;
      w_state_q  <= w_state_d;
      ready_en_q <= ready_en_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      awaddr_q   <= awaddr_d;
      awsize_q   <= awsize_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      mem_q      <= mem_d;
    end
  end

  // Next-state and datapath. NOTE: every comb output gets a default first, so no latches.
  always_comb begin
    ready_en_d = 1'b1;
    r_state_d  = r_state_q;
    w_state_d  = w_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    awaddr_d   = awaddr_q;
    awsize_d   = awsize_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    mem_d      = mem_q;
    w_done     = 1'b0;
    widx       = '0;

    ar_hs = s_axi_arvalid && s_axi_arready;
    aw_hs = s_axi_awvalid && s_axi_awready;
    w_hs  = s_axi_wvalid  && s_axi_wready;

    // Read channel: mem_q is sampled, so a same-edge write is not yet visible.
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        r_state_d = R_RESP;
        rresp_d   = resp_of(s_axi_araddr, s_axi_arsize);
        rdata_d   = (rresp_d == RESP_OKAY) ? mem_q[idx_of(s_axi_araddr)] : 32'h0;
      end
      R_RESP: if (s_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    if (s_axi_rvalid && s_axi_rready) rd_count_d = rd_count_q + 16'd1;

    if (aw_hs) begin
      awaddr_d = s_axi_awaddr;
      awsize_d = s_axi_awsize;
    end
    if (w_hs) begin
      wdata_d = s_axi_wdata;
      wstrb_d = s_axi_wstrb;
    end

    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) w_done    = 1'b1;
        else if (aw_hs)    w_state_d = W_GOT_AW;
        else if (w_hs)     w_state_d = W_GOT_W;
      end
      W_GOT_AW: if (w_hs)         w_done    = 1'b1;
      W_GOT_W:  if (aw_hs)        w_done    = 1'b1;
      W_RESP:   if (s_axi_bready) w_state_d = W_IDLE;
      default:                    w_state_d = W_IDLE;
    endcase

    // The _d copies already hold whichever half arrived this cycle.
    if (w_done) begin
      w_state_d = W_RESP;
      bresp_d   = resp_of(awaddr_d, awsize_d);
      widx      = idx_of(awaddr_d);
      if (bresp_d == RESP_OKAY) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb_d[b]) mem_d[widx][8*b +: 8] = wdata_d[8*b +: 8];
        end
      end
    end
    if (s_axi_bvalid && s_axi_bready) wr_count_d = wr_count_q + 16'd1;
  end

  // Readies stay low until the first edge after reset release.
  always_comb begin
    s_axi_arready = ready_en_q && (r_state_q == R_IDLE);
    s_axi_rvalid  = (r_state_q == R_RESP);
    s_axi_awready = ready_en_q && ((w_state_q == W_IDLE) || (w_state_q == W_GOT_W));
    s_axi_wready  = ready_en_q && ((w_state_q == W_IDLE) || (w_state_q == W_GOT_AW));
    s_axi_bvalid  = (w_state_q == W_RESP);
  end

  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;
  assign s_axi_bresp = bresp_q;
  assign rd_count    = rd_count_q;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_axi_probe_target.sv
// Directed plus randomized bench for axi_probe_target, checked against a word-array model
// that applies the addressing, response and strobe rules directly.
module tb_axi_probe_target;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        m_aresetn;
  logic [31:0] s_axi_araddr, s_axi_awaddr, s_axi_wdata, s_axi_rdata;
  logic [2:0]  s_axi_arsize, s_axi_awsize;
  logic        s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_rresp, s_axi_bresp;
  logic [15:0] rd_count, wr_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic [15:0] model_rd, model_wr;

  always #5 clk = ~clk;

  axi_probe_target #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .m_aresetn(m_aresetn),
    .s_axi_araddr(s_axi_araddr), .s_axi_arsize(s_axi_arsize), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awsize(s_axi_awsize), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_resp(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] off;
    off = addr - BASE;
    if (off >= 32'(DEPTH)) return 2'b11;
    if (size > 3'd2)       return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [2:0] size);
    if (model_resp(addr, size) != 2'b00) return 32'h0;
    return model_mem[addr - BASE];
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] word;
    if (model_resp(addr, size) != 2'b00) return;
    word = model_mem[addr - BASE];
    for (int b = 0; b < 4; b++) if (strb[b]) word[8*b +: 8] = data[8*b +: 8];
    model_mem[addr - BASE] = word;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    model_rd = 16'h0;
    model_wr = 16'h0;
  endtask

  // lead > 0: W goes first by lead cycles; lead < 0: AW goes first; 0: same cycle.
  task automatic do_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input int hold);
    logic [1:0] exp_resp;
    logic keep;
    exp_resp = model_resp(addr, size);
    keep = s_axi_bready;
    @(negedge clk);
    if (lead == 0) begin
      check("aw_ready_idle", 32'(s_axi_awready), 1);
      check("w_ready_idle", 32'(s_axi_wready), 1);
      s_axi_awaddr = addr; s_axi_awsize = size; s_axi_awvalid = 1'b1;
      s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    end else if (lead > 0) begin
      s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
      @(posedge clk); #1;
      s_axi_wvalid = 1'b0;
      for (int i = 0; i < lead; i++) begin
        @(negedge clk);
        check("w_ready_after_w", 32'(s_axi_wready), 0);
        check("aw_ready_after_w", 32'(s_axi_awready), 1);
        check("b_valid_early", 32'(s_axi_bvalid), 0);
      end
      s_axi_awaddr = addr; s_axi_awsize = size; s_axi_awvalid = 1'b1;
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
    end else begin
      s_axi_awaddr = addr; s_axi_awsize = size; s_axi_awvalid = 1'b1;
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
      for (int i = 0; i < -lead; i++) begin
        @(negedge clk);
        check("aw_ready_after_aw", 32'(s_axi_awready), 0);
        check("w_ready_after_aw", 32'(s_axi_wready), 1);
        check("b_valid_early", 32'(s_axi_bvalid), 0);
      end
      s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
      @(posedge clk); #1;
      s_axi_wvalid = 1'b0;
    end
    @(negedge clk);
    check("b_valid", 32'(s_axi_bvalid), 1);
    check("b_resp", 32'(s_axi_bresp), 32'(exp_resp));
    if (!keep) begin
      if (hold > 0) begin
        // Offer a competing write while the response is stalled; it must not be taken.
        s_axi_awaddr = BASE; s_axi_awsize = 3'd2; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          check("b_valid_hold", 32'(s_axi_bvalid), 1);
          check("b_resp_hold", 32'(s_axi_bresp), 32'(exp_resp));
          check("aw_ready_hold", 32'(s_axi_awready), 0);
          check("w_ready_hold", 32'(s_axi_wready), 0);
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      end
      s_axi_bready = 1'b1;
    end
    @(posedge clk); #1;
    if (!keep) s_axi_bready = 1'b0;
    model_write(addr, size, data, strb);
    model_wr++;
    @(negedge clk);
    check("b_valid_done", 32'(s_axi_bvalid), 0);
    check("wr_count", 32'(wr_count), 32'(model_wr));
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] size, input int hold);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic keep;
    exp_data = model_read(addr, size);
    exp_resp = model_resp(addr, size);
    keep = s_axi_rready;
    @(negedge clk);
    check("ar_ready_idle", 32'(s_axi_arready), 1);
    s_axi_araddr = addr; s_axi_arsize = size; s_axi_arvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    @(negedge clk);
    check("r_valid", 32'(s_axi_rvalid), 1);
    check("r_data", s_axi_rdata, exp_data);
    check("r_resp", 32'(s_axi_rresp), 32'(exp_resp));
    if (!keep) begin
      if (hold > 0) begin
        s_axi_araddr = BASE + 32'd1; s_axi_arsize = 3'd2; s_axi_arvalid = 1'b1;
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          check("r_valid_hold", 32'(s_axi_rvalid), 1);
          check("r_data_hold", s_axi_rdata, exp_data);
          check("r_resp_hold", 32'(s_axi_rresp), 32'(exp_resp));
          check("ar_ready_hold", 32'(s_axi_arready), 0);
        end
        s_axi_arvalid = 1'b0;
      end
      s_axi_rready = 1'b1;
    end
    @(posedge clk); #1;
    if (!keep) s_axi_rready = 1'b0;
    model_rd++;
    @(negedge clk);
    check("r_valid_done", 32'(s_axi_rvalid), 0);
    check("rd_count", 32'(rd_count), 32'(model_rd));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arready"}, 32'(s_axi_arready), 0);
    check({tag, "_awready"}, 32'(s_axi_awready), 0);
    check({tag, "_wready"},  32'(s_axi_wready), 0);
    check({tag, "_rvalid"},  32'(s_axi_rvalid), 0);
    check({tag, "_bvalid"},  32'(s_axi_bvalid), 0);
    check({tag, "_rdata"},   s_axi_rdata, 0);
    check({tag, "_rresp"},   32'(s_axi_rresp), 0);
    check({tag, "_bresp"},   32'(s_axi_bresp), 0);
    check({tag, "_rd_count"}, 32'(rd_count), 0);
    check({tag, "_wr_count"}, 32'(wr_count), 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    m_aresetn = 1'b1;
    #1;
    check("ar_ready_before_edge", 32'(s_axi_arready), 0);
    @(posedge clk); #1;
    check("ar_ready_after_edge", 32'(s_axi_arready), 1);
    check("aw_ready_after_edge", 32'(s_axi_awready), 1);
    check("w_ready_after_edge", 32'(s_axi_wready), 1);
  endtask

  initial begin
    logic [31:0] old_word;
    m_aresetn = 1'b0;
    s_axi_araddr = '0; s_axi_arsize = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    s_axi_awaddr = '0; s_axi_awsize = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    model_reset();

    #2;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    release_reset();

    // Same-cycle AW/W with a single byte lane, then readback.
    do_write(BASE + 32'd3, 3'd2, 32'hA5A5_A5A5, 4'b0001, 0, 0);
    check("wr_count_first", 32'(wr_count), 1);
    do_read(BASE + 32'd3, 3'd2, 0);
    check("byte0_readback", model_read(BASE + 32'd3, 3'd2), 32'h0000_00A5);

    // W three cycles before AW.
    do_write(BASE + 32'd7, 3'd2, 32'h1122_3344, 4'b1111, 3, 0);
    do_read(BASE + 32'd7, 3'd2, 0);

    // Address misses and oversized accesses.
    do_read(BASE + 32'(DEPTH), 3'd2, 0);
    do_write(BASE - 32'd1, 3'd2, 32'hFFFF_FFFF, 4'hF, 0, 0);
    do_read(BASE, 3'd3, 0);
    do_write(BASE, 3'd3, 32'hCAFE_F00D, 4'hF, -1, 0);
    for (int i = 0; i < DEPTH; i++) do_read(BASE + 32'(i), 3'd2, 0);

    // Stalled responses.
    do_write(BASE + 32'd9, 3'd1, 32'h0BAD_F00D, 4'b0110, 0, 5);
    do_read(BASE + 32'd9, 3'd2, 5);
    do_read(BASE, 3'd2, 0);

    // Same-edge AR and write commit to one index returns the old word.
    old_word = model_read(BASE + 32'd7, 3'd2);
    @(negedge clk);
    s_axi_awaddr = BASE + 32'd7; s_axi_awsize = 3'd2; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h5566_7788; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_araddr = BASE + 32'd7; s_axi_arsize = 3'd2; s_axi_arvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    @(negedge clk);
    check("coll_r_valid", 32'(s_axi_rvalid), 1);
    check("coll_b_valid", 32'(s_axi_bvalid), 1);
    check("coll_r_data_old", s_axi_rdata, old_word);
    s_axi_rready = 1'b1; s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0; s_axi_bready = 1'b0;
    model_write(BASE + 32'd7, 3'd2, 32'h5566_7788, 4'hF);
    model_rd++; model_wr++;
    @(negedge clk);
    check("coll_rd_count", 32'(rd_count), 32'(model_rd));
    check("coll_wr_count", 32'(wr_count), 32'(model_wr));
    do_read(BASE + 32'd7, 3'd2, 0);

    // Randomized traffic; every other batch keeps the response readies high throughout.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] addr;
      logic [2:0]  size;
      addr = BASE - 32'd2 + 32'($urandom_range(DEPTH + 3));
      size = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : 3'($urandom_range(2));
      s_axi_rready = n[3];
      s_axi_bready = n[3];
      if ($urandom_range(1) == 1)
        do_write(addr, size, $urandom, 4'($urandom_range(15)),
                 $urandom_range(4) - 2, n[3] ? 0 : $urandom_range(2));
      else
        do_read(addr, size, n[3] ? 0 : $urandom_range(2));
    end
    s_axi_rready = 1'b0;
    s_axi_bready = 1'b0;
    for (int i = 0; i < DEPTH; i++) do_read(BASE + 32'(i), 3'd2, 0);

    // Reset with the write FSM holding an AW and a read response pending.
    @(negedge clk);
    s_axi_awaddr = BASE + 32'd5; s_axi_awsize = 3'd2; s_axi_awvalid = 1'b1;
    s_axi_araddr = BASE + 32'd2; s_axi_arsize = 3'd2; s_axi_arvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_r_valid", 32'(s_axi_rvalid), 1);
    check("pre_rst_aw_ready", 32'(s_axi_awready), 0);
    check("pre_rst_w_ready", 32'(s_axi_wready), 1);
    #1;
    m_aresetn = 1'b0;
    #1;
    check_reset_outputs("mid");
    model_reset();
    s_axi_wdata = 32'h7777_7777; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
    release_reset();
    do_read(BASE + 32'd5, 3'd2, 0);
    do_read(BASE + 32'd2, 3'd2, 0);
    do_write(BASE + 32'd5, 3'd2, 32'h0000_ABCD, 4'b0011, 0, 0);
    do_read(BASE + 32'd5, 3'd2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
